// File: rtl/rc4_pkg.sv
// Shared RC4 engine definitions: requester count and indices, the S-RAM
// arbiter state encoding, the latched transaction payload and a one-hot helper.
package rc4_pkg;

    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned DATA_W  = 8;

    typedef logic [IDX_W-1:0]   req_idx_t;
    typedef logic [NUM_REQ-1:0] req_vec_t;
    typedef logic [DATA_W-1:0]  byte_t;

    localparam req_idx_t REQ_INIT = 2'd0;
    localparam req_idx_t REQ_KSA  = 2'd1;
    localparam req_idx_t REQ_PRGA = 2'd2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Transaction captured from the winning requester at acceptance.
    typedef struct packed {
        req_idx_t idx;
        logic     rw;
        byte_t    adr;
        byte_t    wdata;
    } txn_t;

    function automatic req_vec_t idx_onehot(input req_idx_t i);
        return req_vec_t'(1) << i;
    endfunction

endpackage

// File: rtl/s_mem_arbiter_if.sv
// Requester and S-RAM bundle of the S memory arbiter.
// slave  : arbiter view (takes requests and RAM read data, drives RAM and finish)
// master : environment view (requesters plus S RAM)
interface s_mem_arbiter_if;

    localparam int unsigned N = rc4_pkg::NUM_REQ;

    logic [N-1:0]      req_start;
    logic [N-1:0]      req_readWrite;
    logic [N-1:0][7:0] req_adr;
    logic [N-1:0][7:0] req_wdata;
    logic [N-1:0]      req_finish;
    logic [7:0]        rdata;
    logic [7:0]        sAdr;
    logic              sWriteEn;
    logic [7:0]        DataOut_to_s;
    logic [7:0]        DataIn_from_s;
    logic              busy;

    modport slave (
        input  req_start, req_readWrite, req_adr, req_wdata, DataIn_from_s,
        output req_finish, rdata, sAdr, sWriteEn, DataOut_to_s, busy
    );

    modport master (
        output req_start, req_readWrite, req_adr, req_wdata, DataIn_from_s,
        input  req_finish, rdata, sAdr, sWriteEn, DataOut_to_s, busy
    );

endinterface

// File: rtl/s_arb_pick.sv
// Combinational winner selection.
// req_i        : request vector
// last_grant_i : previously granted index; search starts at last_grant_i+1 mod NUM_REQ
// grant_o      : winning index
// valid_o      : any request present
// Holding last_grant_i at NUM_REQ-1 gives plain fixed priority (index 0 highest).
module s_arb_pick
    import rc4_pkg::*;
(
    input  req_vec_t req_i,
    input  req_idx_t last_grant_i,
    output req_idx_t grant_o,
    output logic     valid_o
);

    req_idx_t cand;

    // Rotating search: first set bit after last_grant_i wins.
    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = req_idx_t'((32'(last_grant_i) + k) % NUM_REQ);
            if (!valid_o && req_i[cand]) begin
                grant_o = cand;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/s_mem_arbiter.sv
// Arbiter sharing the single-port S RAM between the init, KSA and PRGA
// requesters. One transaction at a time: IDLE -> ISSUE -> (WAIT -> CAPTURE ->)
// DONE. Writes finish two cycles after acceptance, reads four.
// clk   : system clock
// reset : asynchronous active-low reset
// bus   : s_mem_arbiter_if.slave (requests, finish pulses, rdata, S RAM port, busy)
// Optional: define S_ARB_RR_EN for round-robin selection; default is fixed
// priority init > KSA > PRGA with no last-grant state.
module s_mem_arbiter
    import rc4_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    s_mem_arbiter_if.slave  bus
);

    state_t   state_q, state_d;
    txn_t     txn_q, txn_d;
    byte_t    rdata_q, rdata_d;
    logic     we_q, we_d;
    req_vec_t finish_q, finish_d;
    logic     busy_q, busy_d;

    req_idx_t pick_idx;
    logic     pick_valid;
    req_idx_t last_grant;
    logic     accept;

    assign accept = (state_q == IDLE) && pick_valid;

`ifdef S_ARB_RR_EN
    req_idx_t last_grant_q;

    // Reset value makes requester 0 first in the rotation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= REQ_PRGA;
        end else if (accept) begin
            last_grant_q <= pick_idx;
        end
    end

    assign last_grant = last_grant_q;
`else
    assign last_grant = REQ_PRGA;
`endif

    s_arb_pick u_pick (
        .req_i        (bus.req_start),
        .last_grant_i (last_grant),
        .grant_o      (pick_idx),
        .valid_o      (pick_valid)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_valid) state_d = ISSUE;
            ISSUE:   state_d = txn_q.rw ? DONE : WAIT;
            WAIT:    state_d = CAPTURE;
            CAPTURE: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values, derived from the upcoming state so every
    // output leaves a flop aligned with the state it belongs to.
    always_comb begin
        txn_d    = txn_q;
        rdata_d  = rdata_q;
        we_d     = 1'b0;
        finish_d = '0;
        busy_d   = (state_d != IDLE);
        if (accept) begin
            txn_d.idx   = pick_idx;
            txn_d.rw    = bus.req_readWrite[pick_idx];
            txn_d.adr   = bus.req_adr[pick_idx];
            txn_d.wdata = bus.req_wdata[pick_idx];
        end
        if (state_q == CAPTURE) begin
            rdata_d = bus.DataIn_from_s;
        end
        if (state_d == ISSUE) begin
            we_d = txn_d.rw;
        end
        if (state_d == DONE) begin
            finish_d = idx_onehot(txn_q.idx);
        end
    end

    // Output and latched-transaction registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            txn_q    <= '0;
            rdata_q  <= '0;
            we_q     <= 1'b0;
            finish_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            txn_q    <= txn_d;
            rdata_q  <= rdata_d;
            we_q     <= we_d;
            finish_q <= finish_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.sAdr         = txn_q.adr;
    assign bus.DataOut_to_s = txn_q.wdata;
    assign bus.sWriteEn     = we_q;
    assign bus.rdata        = rdata_q;
    assign bus.req_finish   = finish_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_s_mem_arbiter.sv
// Self-checking bench for s_mem_arbiter: directed scenarios followed by random
// requester traffic, all checked against a transaction-level reference model.
module tb_s_mem_arbiter;
    import rc4_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    s_mem_arbiter_if bus ();

    s_mem_arbiter u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // S RAM: synchronous read, data valid the cycle after the address.
    logic [7:0] ram [256];
    logic       ram_clr;
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'hB8;
        end else if (bus.sWriteEn) begin
            ram[bus.sAdr] <= bus.DataOut_to_s;
        end
        bus.DataIn_from_s <= ram[bus.sAdr];
    end

    int tests;
    int fails;
    int cyc;

    // Requester agents.
    logic       pend [3];
    logic       a_rw [3];
    logic [7:0] a_adr [3];
    logic [7:0] a_wd [3];
    int         keep [3];
    bit         rand_mode;
    bit         rst_hold;

    // Reference model state.
    logic [7:0] ref_mem [256];
    int         m_idle_at, m_issue_cyc, m_fin_cyc, m_idx, m_last;
    logic       m_we;
    logic [7:0] m_adr_l, m_wd_l, m_rd_val, m_rdata;

    int          fin_log [$];
    logic [15:0] we_log [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic new_op(input int i);
        a_rw[i]  = 1'($urandom_range(0, 1));
        a_adr[i] = 8'($urandom);
        a_wd[i]  = 8'($urandom);
    endtask

    task automatic check_outputs();
        logic [31:0] exp_fin;
        if (cyc == m_fin_cyc && !m_we) m_rdata = m_rd_val;
        exp_fin = (cyc == m_fin_cyc) ? (32'd1 << m_idx) : 32'd0;
        chk("req_finish",   32'(bus.req_finish),   exp_fin);
        chk("sWriteEn",     32'(bus.sWriteEn),     32'(cyc == m_issue_cyc && m_we));
        chk("busy",         32'(bus.busy),         32'(cyc < m_idle_at));
        chk("sAdr",         32'(bus.sAdr),         32'(m_adr_l));
        chk("DataOut_to_s", 32'(bus.DataOut_to_s), 32'(m_wd_l));
        chk("rdata",        32'(bus.rdata),        32'(m_rdata));
        if (bus.req_finish != 3'b000) fin_log.push_back(int'(bus.req_finish));
        if (bus.sWriteEn) we_log.push_back({bus.sAdr, bus.DataOut_to_s});
    endtask

    task automatic agents_update();
        if (cyc == m_fin_cyc) begin
            if (keep[m_idx] > 0) keep[m_idx]--;
            else if (rand_mode && $urandom_range(0, 1) == 1) new_op(m_idx);
            else pend[m_idx] = 1'b0;
        end
        if (rand_mode) begin
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    new_op(i);
                end else if (pend[i] && $urandom_range(0, 5) == 0) begin
                    new_op(i);
                end
            end
        end
    endtask

    task automatic drive();
        reset = !rst_hold;
        for (int i = 0; i < 3; i++) begin
            bus.req_start[i]     = pend[i];
            bus.req_readWrite[i] = a_rw[i];
            bus.req_adr[i]       = a_adr[i];
            bus.req_wdata[i]     = a_wd[i];
        end
    endtask

    // Transaction-level model: when idle and requested, pick a winner and
    // schedule its issue/finish cycles from the documented latencies.
    task automatic model_step();
        int w;
        if (rst_hold) begin
            m_idle_at   = cyc + 1;
            m_fin_cyc   = -1;
            m_issue_cyc = -1;
            m_we        = 1'b0;
            m_adr_l     = 8'h00;
            m_wd_l      = 8'h00;
            m_rdata     = 8'h00;
            m_last      = 2;
            return;
        end
        if (cyc >= m_idle_at && (pend[0] || pend[1] || pend[2])) begin
            w = -1;
`ifdef S_ARB_RR_EN
            for (int k = 1; k <= 3; k++) if (w < 0 && pend[(m_last + k) % 3]) w = (m_last + k) % 3;
`else
            for (int c = 0; c < 3; c++) if (w < 0 && pend[c]) w = c;
`endif
            m_last      = w;
            m_idx       = w;
            m_we        = a_rw[w];
            m_adr_l     = a_adr[w];
            m_wd_l      = a_wd[w];
            m_issue_cyc = cyc + 1;
            if (m_we) begin
                ref_mem[a_adr[w]] = a_wd[w];
                m_fin_cyc = cyc + 2;
                m_idle_at = cyc + 3;
            end else begin
                m_rd_val  = ref_mem[a_adr[w]];
                m_fin_cyc = cyc + 4;
                m_idle_at = cyc + 5;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
        agents_update();
        drive();
        model_step();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((pend[0] || pend[1] || pend[2] || cyc < m_idle_at) && n < 200) begin
            cycle();
            n++;
        end
        tests++;
        assert (n < 200) else begin
            fails++;
            $error("FAIL %s drain timeout: observed %0d cycles expected below 200", tag, n);
        end
    endtask

    task automatic check_order(input string tag, input int exp_q[$]);
        chk({tag, "_count"}, 32'(fin_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            chk({tag, "_finish"}, 32'((i < fin_log.size()) ? fin_log[i] : -1), 32'(exp_q[i]));
        end
    endtask

    task automatic clear_logs();
        fin_log.delete();
        we_log.delete();
    endtask

    initial begin
        #500000;
        $error("FAIL watchdog: observed no completion expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ord[$];
        tests = 0; fails = 0; cyc = 0;
        rst_hold = 1'b1; rand_mode = 1'b0; ram_clr = 1'b1; reset = 1'b0;
        m_idle_at = 0; m_fin_cyc = -1; m_issue_cyc = -1; m_idx = 0; m_last = 2;
        m_we = 1'b0; m_adr_l = 8'h00; m_wd_l = 8'h00; m_rd_val = 8'h00; m_rdata = 8'h00;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'hB8;
        for (int i = 0; i < 3; i++) begin
            pend[i] = 1'b0; a_rw[i] = 1'b0; a_adr[i] = 8'h00; a_wd[i] = 8'h00; keep[i] = 0;
        end
        drive();

        // Reset state.
        cycle();
        ram_clr = 1'b0;
        repeat (2) cycle();
        rst_hold = 1'b0;
        cycle();

        // Init write 0x75 to 0x24.
        clear_logs();
        pend[0] = 1'b1; a_rw[0] = 1'b1; a_adr[0] = 8'h24; a_wd[0] = 8'h75;
        drain("init_write");
        ord = '{1};
        check_order("init_write", ord);
        chk("init_we_count", 32'(we_log.size()), 32'd1);
        chk("init_we_bus", 32'((we_log.size() > 0) ? we_log[0] : 16'h0), 32'h2475);

        // KSA read of 0x12 (RAM holds 0xAA there).
        clear_logs();
        pend[1] = 1'b1; a_rw[1] = 1'b0; a_adr[1] = 8'h12;
        drain("ksa_read");
        ord = '{2};
        check_order("ksa_read", ord);
        chk("ksa_rdata", 32'(bus.rdata), 32'hAA);
        chk("ksa_no_we", 32'(we_log.size()), 32'd0);

        // Address changed to 0xFF while the read is in ISSUE.
        pend[1] = 1'b1; a_rw[1] = 1'b0; a_adr[1] = 8'h12;
        cycle();
        a_adr[1] = 8'hFF;
        cycle();
        cycle();
        chk("adr_hold", 32'(bus.sAdr), 32'h12);
        drain("adr_hold");
        chk("adr_hold_rdata", 32'(bus.rdata), 32'hAA);

        // Reset during WAIT of a read, then reissue.
        pend[1] = 1'b1; a_rw[1] = 1'b0; a_adr[1] = 8'h33;
        cycle();
        while (cyc + 1 < m_issue_cyc + 1) cycle();
        rst_hold = 1'b1;
        cycle();
        rst_hold = 1'b0;
        clear_logs();
        cycle();
        chk("abort_finish",   32'(bus.req_finish),   32'd0);
        chk("abort_rdata",    32'(bus.rdata),        32'd0);
        chk("abort_sAdr",     32'(bus.sAdr),         32'd0);
        chk("abort_sWriteEn", 32'(bus.sWriteEn),     32'd0);
        chk("abort_DataOut",  32'(bus.DataOut_to_s), 32'd0);
        chk("abort_busy",     32'(bus.busy),         32'd0);
        chk("abort_no_pulse", 32'(fin_log.size()),   32'd0);
        drain("reissue");
        ord = '{2};
        check_order("reissue", ord);
        chk("reissue_rdata", 32'(bus.rdata), 32'h8B);

        // All three in the same cycle, straight after a reset.
        rst_hold = 1'b1;
        cycle();
        rst_hold = 1'b0;
        clear_logs();
        pend[0] = 1'b1; a_rw[0] = 1'b1; a_adr[0] = 8'h30; a_wd[0] = 8'h01;
        pend[1] = 1'b1; a_rw[1] = 1'b0; a_adr[1] = 8'h24;
        pend[2] = 1'b1; a_rw[2] = 1'b1; a_adr[2] = 8'h40; a_wd[2] = 8'h02;
`ifdef S_ARB_RR_EN
        keep[0] = 1;
        ord = '{1, 2, 4, 1};
`else
        ord = '{1, 2, 4};
`endif
        drain("triple");
        check_order("triple", ord);
        chk("triple_rdata", 32'(bus.rdata), 32'h75);

        // Random traffic.
        rand_mode = 1'b1;
        repeat (3000) cycle();
        rand_mode = 1'b0;
        drain("random");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/s_mem_arbiter.md
S_MEM_ARBITER -- requirements
Module: s_mem_arbiter

Interface
REQ-001 SHALL have clk  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have req_start  input  3  per-requester request level (bit0 init, bit1 KSA, bit2 PRGA), held until own finish.
REQ-004 SHALL have req_readWrite  input  3  per-requester op select, 0 = read, 1 = write.
REQ-005 SHALL have req_adr  input  24  per-requester S address, requester i on bits [8i+7:8i].
REQ-006 SHALL have req_wdata  input  24  per-requester write data, same packing.
REQ-007 SHALL have req_finish  output  3  one-cycle completion pulse to the granted requester only.
REQ-008 SHALL have rdata  output  8  registered read data, shared by all requesters.
REQ-009 SHALL have sAdr  output  8  address to S RAM.
REQ-010 SHALL have sWriteEn  output  1  S RAM write enable.
REQ-011 SHALL have DataOut_to_s  output  8  write data to S RAM.
REQ-012 SHALL have DataIn_from_s  input  8  S RAM read data, valid one cycle after address is presented.
REQ-013 SHALL have busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, ISSUE, WAIT, CAPTURE and DONE.
REQ-015 IDLE: if any req_start bit is high, SHALL select one winner, latch its index, readWrite, adr and wdata, and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-016 Without the Configuration feature, SHALL use fixed priority init > KSA > PRGA.
REQ-017 ISSUE: SHALL drive sWriteEn = latched readWrite for exactly this cycle; on write go to DONE, on read go to WAIT.
REQ-018 WAIT: SHALL transition to CAPTURE; CAPTURE SHALL load rdata from DataIn_from_s and go to DONE.
REQ-019 DONE: SHALL assert req_finish[grant] for exactly this cycle and return to IDLE.
REQ-020 Latency from IDLE acceptance edge: write finish in 2nd following cycle, read finish in 4th; rdata valid from the finish cycle until the next read capture.
REQ-021 sAdr and DataOut_to_s SHALL always drive the latched registers; sWriteEn SHALL be 0 outside ISSUE.
REQ-022 Request changes after acceptance SHALL be ignored until DONE.
REQ-023 A requester still asserting req_start in the IDLE cycle after its finish SHALL be treated as a new request.
REQ-024 Simultaneous requests SHALL be served one per transaction; a losing request SHALL be held pending with no loss.
REQ-025 Back-to-back throughput SHALL be one transaction per 3 cycles for writes and 5 for reads.

Reset
REQ-026 While reset is low, SHALL force state IDLE, req_finish=0, rdata=0, sAdr=0, sWriteEn=0, DataOut_to_s=0 and busy=0.
REQ-027 Reset mid-transaction SHALL abort it with no finish pulse; the requester SHALL reissue it.
REQ-028 Reset SHALL set last_grant = 2 so that requester 0 wins first under round-robin.

Configuration
REQ-029 With S_ARB_RR_EN defined, SHALL use round-robin: search order begins at last_grant+1 mod 3, and last_grant updates on acceptance.
REQ-030 Without S_ARB_RR_EN, SHALL use fixed priority per REQ-016 and SHALL include no last_grant register.

Structure
REQ-031 SHALL take from shared package rc4_pkg: NUM_REQ=3, index constants REQ_INIT/REQ_KSA/REQ_PRGA, and the state enum type.
REQ-032 SHALL place winner selection in sub-module s_arb_pick (combinational): inputs req vector and last_grant, outputs grant index and valid.

Verification
REQ-033 SHALL cover: init writes adr 0x24, data 0x75 -> sWriteEn=1 one cycle with sAdr=0x24, DataOut_to_s=0x75; req_finish=3'b001 two cycles after acceptance.
REQ-034 SHALL cover: KSA reads adr 0x12 with DataIn_from_s=0xAA -> req_finish=3'b010 four cycles after acceptance, rdata=0xAA, sWriteEn never high.
REQ-035 SHALL cover: all three request in same cycle, fixed priority -> finish order 001, 010, 100 with no overlap.
REQ-036 SHALL cover: same as REQ-035 with S_ARB_RR_EN and init re-requesting immediately -> order init, KSA, PRGA, init.
REQ-037 SHALL cover: reset low during WAIT of a read -> all outputs 0 the next cycle, no finish pulse, and a fresh request after reset completes normally.
REQ-038 SHALL cover: req_adr changed to 0xFF during ISSUE -> sAdr holds the latched 0x12.
